// File: rtl/wave_phase_sequencer_if.sv
// Bundle between the wave sequencer and its environment: sample request,
// CORDIC operand/result handshake and corrected sample outputs.
// timeout_o exists only when WAVE_SEQ_WATCHDOG_EN is defined.
interface wave_phase_sequencer_if #(
  parameter int N_FRAC   = 7,
  parameter int PHASE_BW = 16
);
  localparam int W = N_FRAC + 1;

  logic                enable_i;
  logic                sample_tick_i;
  logic [PHASE_BW-1:0] phase_inc_i;
  logic signed [W-1:0] cordic_x_o;
  logic signed [W-1:0] cordic_y_o;
  logic signed [W-1:0] cordic_z_o;
  logic                cordic_valid_o;
  logic signed [W-1:0] cordic_x_i;
  logic signed [W-1:0] cordic_y_i;
  logic                cordic_valid_i;
  logic signed [W-1:0] cos_o;
  logic signed [W-1:0] sin_o;
  logic                sample_valid_o;
  logic                busy_o;
  logic                overrun_o;
`ifdef WAVE_SEQ_WATCHDOG_EN
  logic                timeout_o;
`endif

  // environment side: requests samples and plays the CORDIC
  modport master (
    output enable_i, sample_tick_i, phase_inc_i, cordic_x_i, cordic_y_i, cordic_valid_i,
    input  cordic_x_o, cordic_y_o, cordic_z_o, cordic_valid_o,
           cos_o, sin_o, sample_valid_o, busy_o, overrun_o
`ifdef WAVE_SEQ_WATCHDOG_EN
    , input timeout_o
`endif
  );

  // sequencer side
  modport slave (
    input  enable_i, sample_tick_i, phase_inc_i, cordic_x_i, cordic_y_i, cordic_valid_i,
    output cordic_x_o, cordic_y_o, cordic_z_o, cordic_valid_o,
           cos_o, sin_o, sample_valid_o, busy_o, overrun_o
`ifdef WAVE_SEQ_WATCHDOG_EN
    , output timeout_o
`endif
  );
endinterface

// File: rtl/wave_phase_sequencer.sv
// wave_phase_sequencer: phase accumulator, quadrant fold into the CORDIC
// convergence range (+/-90 deg) and sign fix-up of the rotator results.
// Optional WAIT watchdog: define WAVE_SEQ_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | waiting for an enabled sample tick
// ISSUE  | operands registered; start strobe raised on the next cycle
// WAIT   | CORDIC iterating, operands held stable
// OUTPUT | corrected sample presented, phase advanced
module wave_phase_sequencer #(
  parameter int N_FRAC      = 7,
  parameter int PHASE_BW    = 16,
  parameter int CORDIC_GAIN = 78
) (
  input logic                   clk_i,
  input logic                   rst_i,
  wave_phase_sequencer_if.slave bus
);
  localparam int W = N_FRAC + 1;
  localparam logic [W-1:0] C_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] C_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_GAIN = W'(CORDIC_GAIN);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUTPUT} state_t;

  state_t              r_state, w_next;
  logic [PHASE_BW-1:0] r_phase;
  logic [W-1:0]        r_cx, r_cy, r_cz, r_cos, r_sin;
  logic                r_flip, r_cvalid, r_svalid, r_overrun;
  logic                w_tick, w_flip;
  logic [W-1:0]        w_a, w_z, w_cos, w_sin;
`ifdef WAVE_SEQ_WATCHDOG_EN
  logic [3:0]          r_wd;
  logic                r_timeout;
  logic                w_wd_expire;
`endif

  // Negation that clips the single unrepresentable case (-min) to +max.
  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
    logic [W-1:0] res;
    res = (v == C_MIN) ? C_MAX : -v;
    return res;
  endfunction

  assign w_tick = bus.sample_tick_i & bus.enable_i;
  assign w_a    = r_phase[PHASE_BW-1 -: W];
  // Quadrants 1 and 2 are rotated by 180 deg; the result is negated afterwards.
  assign w_flip = w_a[W-1] ^ w_a[W-2];
  assign w_z    = w_flip ? {~w_a[W-1], w_a[W-2:0]} : w_a;
  assign w_cos  = r_flip ? sat_neg(bus.cordic_x_i) : bus.cordic_x_i;
  assign w_sin  = r_flip ? sat_neg(bus.cordic_y_i) : bus.cordic_y_i;
`ifdef WAVE_SEQ_WATCHDOG_EN
  assign w_wd_expire = (r_state == S_WAIT) && !bus.cordic_valid_i && (r_wd == 4'd0);
`endif

  assign bus.cordic_x_o     = r_cx;
  assign bus.cordic_y_o     = r_cy;
  assign bus.cordic_z_o     = r_cz;
  assign bus.cordic_valid_o = r_cvalid;
  assign bus.cos_o          = r_cos;
  assign bus.sin_o          = r_sin;
  assign bus.sample_valid_o = r_svalid;
  assign bus.busy_o         = (r_state != S_IDLE);
  assign bus.overrun_o      = r_overrun;
`ifdef WAVE_SEQ_WATCHDOG_EN
  assign bus.timeout_o      = r_timeout;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_tick) w_next = S_ISSUE;
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT: begin
        if (bus.cordic_valid_i) w_next = S_OUTPUT;
`ifdef WAVE_SEQ_WATCHDOG_EN
        else if (w_wd_expire) w_next = S_IDLE;
`endif
      end
      S_OUTPUT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operand capture, result correction, strobes and phase accumulation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_phase   <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_cz      <= '0;
      r_flip    <= 1'b0;
      r_cos     <= '0;
      r_sin     <= '0;
      r_cvalid  <= 1'b0;
      r_svalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // strobe lands one cycle after ISSUE so operands are already settled
      r_cvalid  <= (r_state == S_ISSUE);
      r_svalid  <= 1'b0;
      r_overrun <= w_tick && (r_state != S_IDLE);
      if ((r_state == S_IDLE) && w_tick) begin
        r_cx   <= C_GAIN;
        r_cy   <= '0;
        r_cz   <= w_z;
        r_flip <= w_flip;
      end
      if ((r_state == S_WAIT) && bus.cordic_valid_i) begin
        r_cos    <= w_cos;
        r_sin    <= w_sin;
        r_svalid <= 1'b1;
      end
      if (r_state == S_OUTPUT) r_phase <= r_phase + bus.phase_inc_i;
    end
  end

`ifdef WAVE_SEQ_WATCHDOG_EN
  // Down-counts the remaining WAIT cycles; terminal count abandons the sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd      <= 4'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_expire;
      if (r_state == S_ISSUE)
        r_wd <= 4'd14;
      else if ((r_state == S_WAIT) && (r_wd != 4'd0))
        r_wd <= r_wd - 4'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wave_phase_sequencer.sv
// Bench for wave_phase_sequencer: ideal CORDIC stub, timeline model of the
// expected outputs checked every cycle, plus literal sample checks.
module tb_wave_phase_sequencer;
  localparam real TWO_PI = 6.283185307179586;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  wave_phase_sequencer_if #(.N_FRAC(7), .PHASE_BW(16)) bus ();
  wave_phase_sequencer #(.N_FRAC(7), .PHASE_BW(16), .CORDIC_GAIN(78)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  // stub / model state
  int          stub_mode = 0;   // 0 ideal, 1 x forced to -128, 2 never answers
  int          stub_due  = -1;
  int          stub_z    = 0;
  bit          pend      = 1'b0;
  int          t_acc = -100, t_resp = -1, t_ovr = -10;
  logic [15:0] m_phase = '0;
  int          m_x = 0, m_z = 0, m_cos = 0, m_sin = 0, e_cos = 0, e_sin = 0;
  int          n_cv = 0, n_sv = 0, n_ovr = 0, n_to = 0;
  int          cap_z[$], cap_cos[$], cap_sin[$];

  function automatic int rnd(real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int sat_neg_i(int v);
    return (v == -128) ? 127 : -v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of when things must happen, derived from tick/response timestamps.
  always @(negedge clk_i) begin : model_cmp
    bit e_cv, e_sv, e_busy, e_to, flip;
    int a;
    if (rst_i) begin
      pend = 1'b0; m_phase = '0; m_x = 0; m_z = 0; m_cos = 0; m_sin = 0; t_ovr = -10;
    end
    e_cv = pend && (cyc == t_acc + 2);
    e_sv = pend && (t_resp >= 0) && (cyc == t_resp + 1);
    e_to = 1'b0;
`ifdef WAVE_SEQ_WATCHDOG_EN
    e_to = pend && (t_resp < 0) && (cyc == t_acc + 17);
    chk("timeout", bus.timeout_o, e_to);
    if (bus.timeout_o) n_to++;
`endif
    e_busy = pend && (cyc > t_acc) && !e_to;
    chk("cordic_valid", bus.cordic_valid_o, e_cv);
    chk("sample_valid", bus.sample_valid_o, e_sv);
    chk("busy", bus.busy_o, e_busy);
    chk("overrun", bus.overrun_o, (cyc == t_ovr + 1));
    chk("cordic_x", bus.cordic_x_o, m_x);
    chk("cordic_y", bus.cordic_y_o, 0);
    chk("cordic_z", bus.cordic_z_o, m_z);
    chk("cos", bus.cos_o, m_cos);
    chk("sin", bus.sin_o, m_sin);
    if (bus.cordic_valid_o) begin
      n_cv++;
      cap_z.push_back(bus.cordic_z_o);
      if (stub_mode != 2) begin
        stub_due = cyc + 7;
        stub_z   = bus.cordic_z_o;
      end
    end
    if (bus.sample_valid_o) begin
      n_sv++;
      cap_cos.push_back(bus.cos_o);
      cap_sin.push_back(bus.sin_o);
    end
    if (bus.overrun_o) n_ovr++;
    if (e_sv) begin
      pend = 1'b0;
      m_phase = m_phase + bus.phase_inc_i;
    end
    if (e_to) pend = 1'b0;
    if (pend && (t_resp < 0) && bus.cordic_valid_i && (cyc >= t_acc + 2)) begin
      t_resp = cyc; m_cos = e_cos; m_sin = e_sin;
    end
    if (!rst_i && bus.sample_tick_i && bus.enable_i) begin
      if (e_busy) t_ovr = cyc;
      else begin
        pend = 1'b1; t_acc = cyc; t_resp = -1;
        a = int'(m_phase[15:8]);
        flip = (a >= 64) && (a < 192);
        if (flip)          m_z = a - 128;
        else if (a >= 128) m_z = a - 256;
        else               m_z = a;
        m_x   = 78;
        e_sin = rnd(127.0 * $sin(TWO_PI * a / 256.0));
        if (stub_mode == 1) e_cos = flip ? sat_neg_i(-128) : -128;
        else                e_cos = rnd(127.0 * $cos(TWO_PI * a / 256.0));
      end
    end
    cyc++;
  end

  // Ideal CORDIC: answers 7 cycles after its start strobe.
  initial begin : cordic_stub
    bus.cordic_valid_i = 1'b0;
    bus.cordic_x_i     = '0;
    bus.cordic_y_i     = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (cyc == stub_due) begin
        bus.cordic_valid_i = 1'b1;
        bus.cordic_y_i     = 8'(rnd(127.0 * $sin(TWO_PI * stub_z / 256.0)));
        if (stub_mode == 1) bus.cordic_x_i = -8'sd128;
        else                bus.cordic_x_i = 8'(rnd(127.0 * $cos(TWO_PI * stub_z / 256.0)));
      end else begin
        bus.cordic_valid_i = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic pulse_tick();
    bus.sample_tick_i = 1'b1;
    step(1);
    bus.sample_tick_i = 1'b0;
  endtask

  task automatic wait_sample(input int budget);
    int start = n_sv;
    int i = 0;
    while ((n_sv == start) && (i < budget)) begin
      step(1);
      i++;
    end
    chk("wait_sample", n_sv - start, 1);
  endtask

  initial begin : limit
    #100000;
    $display("FAIL sim_time_limit got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int n0, o0, c0;
    int zq;
    bus.enable_i      = 1'b0;
    bus.sample_tick_i = 1'b0;
    bus.phase_inc_i   = '0;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_cos", bus.cos_o, 0);
    chk("rst_sin", bus.sin_o, 0);
    chk("rst_cordic_x", bus.cordic_x_o, 0);
    chk("rst_cordic_z", bus.cordic_z_o, 0);
    chk("rst_cordic_valid", bus.cordic_valid_o, 0);
    chk("rst_sample_valid", bus.sample_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_overrun", bus.overrun_o, 0);
    step(2);
    rst_i = 1'b0;
    step(2);

    // quarter-turn steps, fifth sample shows the wrap back to 0
    bus.enable_i    = 1'b1;
    bus.phase_inc_i = 16'h4000;
    for (int k = 0; k < 5; k++) begin
      pulse_tick();
      wait_sample(30);
      step(2);
    end
    chk("q_z0", cap_z[0], 0);    chk("q_cos0", cap_cos[0], 127);  chk("q_sin0", cap_sin[0], 0);
    chk("q_z1", cap_z[1], -64);  chk("q_cos1", cap_cos[1], 0);    chk("q_sin1", cap_sin[1], 127);
    chk("q_z2", cap_z[2], 0);    chk("q_cos2", cap_cos[2], -127); chk("q_sin2", cap_sin[2], 0);
    chk("q_z3", cap_z[3], -64);  chk("q_cos3", cap_cos[3], 0);    chk("q_sin3", cap_sin[3], -127);
    chk("wrap_z", cap_z[4], 0);  chk("wrap_cos", cap_cos[4], 127);

    // second tick two cycles after the first is dropped
    n0 = n_sv; o0 = n_ovr;
    pulse_tick();
    step(1);
    pulse_tick();
    wait_sample(30);
    step(3);
    chk("ovr_samples", n_sv - n0, 1);
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_z", cap_z[5], -64);

    // phase 0x8000: flipped, CORDIC x = -128 saturates to +127
    stub_mode = 1;
    pulse_tick();
    wait_sample(30);
    step(2);
    stub_mode = 0;
    chk("sat_z", cap_z[6], 0);
    chk("sat_cos", cap_cos[6], 127);

    // disabled ticks are ignored without overrun, phase held at 0xC000
    c0 = n_cv; o0 = n_ovr;
    bus.enable_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse_tick();
      step(2);
    end
    chk("dis_strobes", n_cv - c0, 0);
    chk("dis_overrun", n_ovr - o0, 0);
    bus.enable_i = 1'b1;
    pulse_tick();
    wait_sample(30);
    step(2);
    chk("dis_z", cap_z[7], -64);
    chk("dis_cos", cap_cos[7], 0);
    chk("dis_sin", cap_sin[7], -127);

    // off-axis angles
    bus.phase_inc_i = 16'h1A00;
    for (int k = 0; k < 4; k++) begin
      pulse_tick();
      wait_sample(30);
      step(2);
    end
    chk("mix_z1", cap_z[9], 26);
    chk("mix_cos1", cap_cos[9], 102);
    chk("mix_sin1", cap_sin[9], 76);

    // reset while waiting on the CORDIC; its late answer must be ignored
    n0 = n_sv;
    pulse_tick();
    step(3);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_cos", bus.cos_o, 0);
    chk("mid_rst_sin", bus.sin_o, 0);
    chk("mid_rst_cordic_x", bus.cordic_x_o, 0);
    chk("mid_rst_cordic_z", bus.cordic_z_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_cordic_valid", bus.cordic_valid_o, 0);
    step(2);
    rst_i = 1'b0;
    step(12);
    chk("mid_rst_no_sample", n_sv - n0, 0);
    pulse_tick();
    wait_sample(30);
    step(2);
    chk("restart_z", cap_z[$], 0);
    chk("restart_cos", cap_cos[$], 127);

`ifdef WAVE_SEQ_WATCHDOG_EN
    // CORDIC never answers: abandon, then reissue the same angle
    stub_mode = 2;
    o0 = n_to; n0 = n_sv;
    pulse_tick();
    for (int i = 0; (i < 40) && (n_to == o0); i++) step(1);
    chk("wd_timeout", n_to - o0, 1);
    chk("wd_no_sample", n_sv - n0, 0);
    zq = cap_z[$];
    chk("wd_first_z", zq, 26);
    stub_mode = 0;
    step(2);
    pulse_tick();
    wait_sample(30);
    step(2);
    chk("wd_reissue_z", cap_z[$], zq);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
